// File: rtl/stream_transposer_pkg.sv
// Shared helpers for the streaming transposer: pointer sizing only, since
// every width is derived per instance from D1_WIDTH / D2_WIDTH.
package stream_transposer_pkg;

   // Width of a pointer that counts 0..n-1; never narrower than one bit.
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/transposer_bank.sv
// One ping-pong bank: a D1_WIDTH x D2_WIDTH register array written a row
// at a time and read a column at a time through a combinational mux.
// Contents are deliberately not reset; the full flags in the top decide
// whether anything stored here is meaningful.
module transposer_bank
   import stream_transposer_pkg::*;
#(
   parameter int D1_WIDTH = 8,
   parameter int D2_WIDTH = 3
) (
   input  logic                          clk,
   input  logic                          i_we,
   input  logic [ptr_w(D1_WIDTH)-1:0]    i_wr_row,
   input  logic [D2_WIDTH-1:0]           i_wr_data,
   input  logic [ptr_w(D2_WIDTH)-1:0]    i_rd_col,
   output logic [D1_WIDTH-1:0]           o_rd_col
);

   localparam int RW = ptr_w(D1_WIDTH);
   localparam int CW = ptr_w(D2_WIDTH);

   logic [D2_WIDTH-1:0] r_mem [D1_WIDTH];

   // Row write: decoded compare keeps out-of-range pointer codes harmless.
   always_ff @(posedge clk) begin
      for (int r = 0; r < D1_WIDTH; r++) begin
         if (i_we && (i_wr_row == RW'(r))) begin
            r_mem[r] <= i_wr_data;
         end
      end
   end

   // Column read: bit i of the output is row i, bit i_rd_col.
   always_comb begin
      o_rd_col = '0;
      for (int i = 0; i < D1_WIDTH; i++) begin
         for (int j = 0; j < D2_WIDTH; j++) begin
            if (i_rd_col == CW'(j)) begin
               o_rd_col[i] = r_mem[i][j];
            end
         end
      end
   end

endmodule

// File: rtl/stream_transposer.sv
// Streaming matrix transposer: rows of D2_WIDTH bits in, columns of
// D1_WIDTH bits out, through two ping-pong banks so one matrix can be
// filled while the other drains.
//
// Handshake: a beat moves on a rising edge where valid & ready are both
// high. in_ready depends only on the write bank's full flag and out_valid
// only on the read bank's full flag, so neither looks at the partner's
// valid/ready combinationally.
module stream_transposer
   import stream_transposer_pkg::*;
#(
   parameter int D1_WIDTH = 8,
   parameter int D2_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [D2_WIDTH-1:0]  in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 in_last,
   output logic [D1_WIDTH-1:0]  out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   localparam int WP_W = ptr_w(D1_WIDTH);
   localparam int RP_W = ptr_w(D2_WIDTH);
   localparam logic [WP_W-1:0] WP_LAST = WP_W'(D1_WIDTH - 1);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(D2_WIDTH - 1);

   logic [1:0]          r_full;
   logic                r_wr_bank;
   logic                r_rd_bank;
   logic [WP_W-1:0]     r_wr_ptr;
   logic [RP_W-1:0]     r_rd_ptr;

   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_wr_last;
   logic                w_rd_last;
   logic                w_wr_done;
   logic                w_rd_done;
   logic [1:0]          w_full_nxt;
   logic [1:0]          w_bank_we;
   logic [D1_WIDTH-1:0] w_bank_col [2];

   assign w_in_ready  = ~r_full[r_wr_bank];
   assign w_out_valid = r_full[r_rd_bank];
   assign w_in_fire   = in_valid & w_in_ready;
   assign w_out_fire  = w_out_valid & out_ready;
   assign w_wr_last   = (r_wr_ptr == WP_LAST);
   assign w_rd_last   = (r_rd_ptr == RP_LAST);
   assign w_wr_done   = w_in_fire & w_wr_last;
   assign w_rd_done   = w_out_fire & w_rd_last;

   assign in_ready  = w_in_ready;
   assign in_last   = w_wr_last;
   assign out_valid = w_out_valid;
   assign out_last  = w_out_valid & w_rd_last;
   assign out_data  = r_rd_bank ? w_bank_col[1] : w_bank_col[0];

   // Route the input row to whichever bank is currently being filled.
   always_comb begin
      w_bank_we            = '0;
      w_bank_we[r_wr_bank] = w_in_fire;
   end

   // Full-flag update. A completing write and a completing read always hit
   // different banks (write bank is empty, read bank is full), so both
   // updates can land on the same edge without conflict.
   always_comb begin
      w_full_nxt = r_full;
      if (w_wr_done) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
      if (w_rd_done) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
   end

   // Full flags: cleared by reset, which discards any buffered matrix.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_full <= '0;
      end else begin
         r_full <= w_full_nxt;
      end
   end

   // Write side: advance the row pointer, swap banks after the last row.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_wr_ptr  <= '0;
         r_wr_bank <= 1'b0;
      end else if (w_in_fire) begin
         if (w_wr_last) begin
            r_wr_ptr  <= '0;
            r_wr_bank <= ~r_wr_bank;
         end else begin
            r_wr_ptr  <= r_wr_ptr + WP_W'(1);
         end
      end
   end

   // Read side: advance the column pointer, release the bank after the last
   // column. With both banks empty nothing fires and the pointer holds.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_rd_ptr  <= '0;
         r_rd_bank <= 1'b0;
      end else if (w_out_fire) begin
         if (w_rd_last) begin
            r_rd_ptr  <= '0;
            r_rd_bank <= ~r_rd_bank;
         end else begin
            r_rd_ptr  <= r_rd_ptr + RP_W'(1);
         end
      end
   end

   // Two identical banks; the top owns all pointer and flag state.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      transposer_bank #(
         .D1_WIDTH (D1_WIDTH),
         .D2_WIDTH (D2_WIDTH)
      ) u_bank (
         .clk       (clk),
         .i_we      (w_bank_we[b]),
         .i_wr_row  (r_wr_ptr),
         .i_wr_data (in_data),
         .i_rd_col  (r_rd_ptr),
         .o_rd_col  (w_bank_col[b])
      );
   end

endmodule

// File: tb/tb_stream_transposer.sv
// Bench for stream_transposer: an 8x3 instance (a_*) for most scenarios and
// a 3x8 instance (b_*) for the output-limited case. Each instance has a
// scoreboard fed at input acceptance and drained at output acceptance.
`timescale 1ns/1ps
module tb_stream_transposer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT A: D1=8, D2=3 ----------------
   logic [2:0] a_in_data = '0;
   logic       a_in_valid = 1'b0;
   logic       a_in_ready, a_in_last;
   logic [7:0] a_out_data;
   logic       a_out_valid, a_out_last;
   logic       a_out_ready = 1'b0;

   stream_transposer #(.D1_WIDTH(8), .D2_WIDTH(3)) u_dut_a (
      .clk       (clk),
      .nrst      (nrst),
      .in_data   (a_in_data),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_last   (a_in_last),
      .out_data  (a_out_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_last  (a_out_last)
   );

   // ---------------- DUT B: D1=3, D2=8 ----------------
   logic [7:0] b_in_data = '0;
   logic       b_in_valid = 1'b0;
   logic       b_in_ready, b_in_last;
   logic [2:0] b_out_data;
   logic       b_out_valid, b_out_last;
   logic       b_out_ready = 1'b0;

   stream_transposer #(.D1_WIDTH(3), .D2_WIDTH(8)) u_dut_b (
      .clk       (clk),
      .nrst      (nrst),
      .in_data   (b_in_data),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_last   (b_in_last),
      .out_data  (b_out_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_last  (b_out_last)
   );

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboards ----------------
   // Entries are {last, column}.
   logic [8:0] a_exp_q[$];
   logic [3:0] b_exp_q[$];
   logic [7:0] a_obs_q[$];
   logic [2:0] a_rows [8];
   logic [7:0] b_rows [3];
   int         a_wr = 0;
   int         b_wr = 0;
   bit         a_cont = 1'b0;
   int         a_stalls = 0;

   // Transfers happen on the next rising edge; signals are stable here.
   always @(negedge clk) begin
      logic [8:0] e;
      logic [7:0] col;
      if (!nrst) begin
         a_wr = 0;
         a_exp_q.delete();
      end else begin
         if (a_cont && a_in_valid && !a_in_ready) a_stalls++;
         if (a_in_valid && a_in_ready) begin
            check("a_in_last", a_in_last, (a_wr == 7));
            a_rows[a_wr] = a_in_data;
            if (a_wr == 7) begin
               for (int j = 0; j < 3; j++) begin
                  for (int i = 0; i < 8; i++) col[i] = a_rows[i][j];
                  a_exp_q.push_back({(j == 2), col});
               end
               a_wr = 0;
            end else begin
               a_wr++;
            end
         end
         if (a_out_valid && a_out_ready) begin
            if (a_exp_q.size() == 0) begin
               check("a_unexpected_out", 1, 0);
            end else begin
               e = a_exp_q.pop_front();
               check("a_out_data", a_out_data, e[7:0]);
               check("a_out_last", a_out_last, e[8]);
               a_obs_q.push_back(a_out_data);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] e;
      logic [2:0] col;
      if (!nrst) begin
         b_wr = 0;
         b_exp_q.delete();
      end else begin
         if (b_in_valid && b_in_ready) begin
            b_rows[b_wr] = b_in_data;
            if (b_wr == 2) begin
               for (int j = 0; j < 8; j++) begin
                  for (int i = 0; i < 3; i++) col[i] = b_rows[i][j];
                  b_exp_q.push_back({(j == 7), col});
               end
               b_wr = 0;
            end else begin
               b_wr++;
            end
         end
         if (b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
               check("b_unexpected_out", 1, 0);
            end else begin
               e = b_exp_q.pop_front();
               check("b_out_data", b_out_data, e[2:0]);
               check("b_out_last", b_out_last, e[3]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Offer one row on A and return just after the edge that accepts it.
   task automatic a_send(input logic [2:0] d);
      int t;
      a_in_data  = d;
      a_in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!a_in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("a_send_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic a_drain();
      int t;
      t = 0;
      while (a_exp_q.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("a_drain", a_exp_q.size(), 0);
   endtask

   task automatic a_check_idle(input string tag);
      check({tag, "_in_ready"}, a_in_ready, 1);
      check({tag, "_out_valid"}, a_out_valid, 0);
      check({tag, "_out_last"}, a_out_last, 0);
      check({tag, "_in_last"}, a_in_last, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      bit seen;
      int rows, win, t;
      bit dropped;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      a_check_idle("rst_a");
      check("rst_b_in_ready", b_in_ready, 1);
      check("rst_b_out_valid", b_out_valid, 0);

      // Ramp: row i = i, with output latency check
      a_out_ready = 1'b1;
      a_obs_q.delete();
      for (int i = 0; i < 7; i++) a_send(3'(i));
      check("ramp_valid_before", a_out_valid, 0);
      a_send(3'd7);
      a_in_valid = 1'b0;
      check("ramp_valid_after", a_out_valid, 1);
      a_drain();
      check("ramp_cnt", a_obs_q.size(), 3);
      if (a_obs_q.size() == 3) begin
         check("ramp_col0", a_obs_q[0], 8'hAA);
         check("ramp_col1", a_obs_q[1], 8'hCC);
         check("ramp_col2", a_obs_q[2], 8'hF0);
      end

      // Single set bit in row 0
      a_obs_q.delete();
      a_send(3'b001);
      for (int i = 1; i < 8; i++) a_send(3'b000);
      a_in_valid = 1'b0;
      a_drain();
      check("bit_cnt", a_obs_q.size(), 3);
      if (a_obs_q.size() == 3) begin
         check("bit_col0", a_obs_q[0], 8'h01);
         check("bit_col1", a_obs_q[1], 8'h00);
         check("bit_col2", a_obs_q[2], 8'h00);
      end

      // Backpressure: fill both banks, then release
      a_out_ready = 1'b0;
      for (int i = 0; i < 16; i++) a_send(3'($urandom_range(0, 7)));
      a_in_valid = 1'b0;
      check("bp_in_ready_low", a_in_ready, 0);
      check("bp_out_valid", a_out_valid, 1);
      a_out_ready = 1'b1;
      seen = 1'b0;
      t = 0;
      while (!seen && t < 20) begin
         @(negedge clk);
         if (a_out_valid && a_out_last) begin
            seen = 1'b1;
            check("bp_ready_at_last", a_in_ready, 0);
            @(posedge clk);
            #1;
            check("bp_ready_after_last", a_in_ready, 1);
         end
         t++;
      end
      check("bp_last_seen", seen, 1);
      a_drain();

      // Continuous stream, 4 random matrices, never stalled
      @(posedge clk);
      #1;
      a_cont   = 1'b1;
      a_stalls = 0;
      for (int i = 0; i < 32; i++) a_send(3'($urandom_range(0, 7)));
      a_in_valid = 1'b0;
      a_cont     = 1'b0;
      check("cont_stalls", a_stalls, 0);
      a_drain();

      // Mid-operation reset: one full bank plus 5 rows of the next matrix
      a_out_ready = 1'b0;
      for (int i = 0; i < 13; i++) a_send(3'($urandom_range(0, 7)));
      a_in_valid = 1'b0;
      nrst = 1'b0;
      @(posedge clk);
      #1;
      nrst = 1'b1;
      a_check_idle("mid_rst");
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) a_send(3'($urandom_range(0, 7)));
      a_in_valid = 1'b0;
      a_drain();

      // Output-limited instance: D1=3, D2=8
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_data   = 8'($urandom_range(0, 255));
      rows = 0;
      win = 0;
      dropped = 1'b0;
      for (int cyc = 0; cyc < 300 && rows < 36; cyc++) begin
         bit acc;
         @(negedge clk);
         acc = b_in_ready;
         if (acc) begin
            rows++;
         end else if (!dropped) begin
            dropped = 1'b1;
            check("b_rows_before_drop", rows, 6);
         end
         if (cyc >= 24 && cyc < 72 && acc) win++;
         @(posedge clk);
         #1;
         if (acc) b_in_data = 8'($urandom_range(0, 255));
      end
      b_in_valid = 1'b0;
      check("b_dropped", dropped, 1);
      check("b_rows_done", rows, 36);
      check("b_window_rate", win, 18);
      t = 0;
      while (b_exp_q.size() != 0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("b_drain", b_exp_q.size(), 0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
